// File: rtl/instruction_fetch.sv
// Instruction fetch unit: single-outstanding memory request, one-entry output buffer,
// PC-relative / register redirects with drop of in-flight data.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        BrTaken,
  input  logic        UncondBr,
  input  logic [63:0] br_pc,
  input  logic [31:0] br_instr,
  input  logic        BrReg,
  input  logic [63:0] reg_target
);

  typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

  state_t      state, state_next;
  logic [63:0] pc, pc_next;
  logic [63:0] pending, pending_next;
  logic [63:0] br_target, target;
  logic        outstanding;
  logic        redirect, hold, ack;

  assign redirect  = BrTaken | BrReg;
  assign hold      = instr_valid & stall;
  assign imem_addr = pc;
  assign ack       = imem_req & imem_ack;

  always_comb begin
    if (UncondBr)
      br_target = br_pc + {{36{br_instr[25]}}, br_instr[25:0], 2'b00};
    else
      br_target = br_pc + {{43{br_instr[23]}}, br_instr[23:5], 2'b00};
    target = BrReg ? reg_target : br_target;
  end

  always_comb begin
    imem_req = 1'b0;
    case (state)
      IDLE:    imem_req = 1'b0;
      FETCH:   imem_req = outstanding | ~hold;
      DROP:    imem_req = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  // An ack that lands while the buffer is full and stalled is dropped and the
  // same PC is re-requested later, so the stream never skips an instruction.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    pending_next = pending;
    case (state)
      IDLE: begin
        state_next = FETCH;
        if (redirect) pc_next = target;
      end
      FETCH: begin
        if (redirect) begin
          if (imem_req && !imem_ack) begin
            pending_next = target;
            state_next   = DROP;
          end else begin
            pc_next = target;
          end
        end else if (ack && !hold) begin
          pc_next = pc + 64'd4;
        end
      end
      DROP: begin
        if (ack) begin
          pc_next    = redirect ? target : pending;
          state_next = FETCH;
        end else if (redirect) begin
          pending_next = target;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      pending     <= '0;
      outstanding <= 1'b0;
      instruction <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      pending     <= pending_next;
      outstanding <= imem_req & ~imem_ack;
      if (redirect) begin
        instr_valid <= 1'b0;
      end else if (state == FETCH && ack && !hold) begin
        instruction <= imem_rdata;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
      end else if (!stall) begin
        instr_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios, a redirect-target
// table, and a randomized run checked against an instruction-stream model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        BrTaken, UncondBr, BrReg;
  logic [63:0] br_pc, reg_target;
  logic [31:0] br_instr;

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(64'h0)) dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .BrTaken(BrTaken), .UncondBr(UncondBr), .br_pc(br_pc), .br_instr(br_instr),
    .BrReg(BrReg), .reg_target(reg_target)
  );

  typedef struct {
    string       name;
    logic        brtaken;
    logic        brreg;
    logic        uncond;
    logic [63:0] bpc;
    logic [31:0] binstr;
    logic [63:0] rtarget;
    logic [63:0] exp_addr;
  } br_vec_t;

  br_vec_t     br_tab[8];

  int          vectors = 0;
  int          miscompares = 0;
  bit          mem_manual;
  int          mem_maxlat;
  bit          mem_active;
  int          mem_lat;
  bit          model_en = 1'b0;
  logic [63:0] exp_pc;
  int          consumed = 0;
  logic [63:0] a_hold;

  logic        pre_valid, pre_stall, pre_redirect, pre_req, pre_ack, pre_reset;
  logic [63:0] pre_addr, pre_ipc, pre_target;
  logic [31:0] pre_instr;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'd2654435761) ^ a[63:32] ^ 32'h5A5AC3C3;
  endfunction

  // Target computed from the branch rules with plain signed arithmetic.
  function automatic logic [63:0] model_target();
    longint off;
    if (BrReg) return reg_target;
    if (UncondBr) begin
      off = longint'(br_instr[25:0]);
      if (br_instr[25]) off = off - (longint'(1) << 26);
    end else begin
      off = longint'(br_instr[23:5]);
      if (br_instr[23]) off = off - (longint'(1) << 19);
    end
    return br_pc + 64'(off * 4);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mem_respond();
    if (mem_manual) return;
    if (reset || !imem_req) begin
      mem_active = 1'b0;
      imem_ack   = 1'b0;
    end else begin
      if (!mem_active) begin
        mem_active = 1'b1;
        mem_lat    = int'($urandom_range(0, mem_maxlat));
      end else if (mem_lat > 0) begin
        mem_lat--;
      end
      imem_ack = (mem_lat == 0);
    end
    imem_rdata = imem_ack ? mem_word(imem_addr) : 32'h0;
  endtask

  task automatic model_check();
    if (pre_reset) begin
      exp_pc = 64'h0;
      return;
    end
    if (pre_req && !pre_ack) begin
      chk("req_held", 64'(imem_req), 64'd1);
      chk("addr_held", imem_addr, pre_addr);
    end
    if (pre_redirect) begin
      chk("flush", 64'(instr_valid), 64'd0);
      exp_pc = pre_target;
    end else if (pre_valid && pre_stall) begin
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_pc", instr_pc, pre_ipc);
      chk("stall_instr", 64'(instruction), 64'(pre_instr));
    end else if (pre_valid) begin
      chk("stream_pc", pre_ipc, exp_pc);
      chk("stream_data", 64'(pre_instr), 64'(mem_word(pre_ipc)));
      exp_pc = exp_pc + 64'd4;
      consumed++;
    end
  endtask

  task automatic tick();
    #1;
    mem_respond();
    #1;
    pre_valid    = instr_valid;
    pre_stall    = stall;
    pre_redirect = BrTaken | BrReg;
    pre_req      = imem_req;
    pre_ack      = imem_ack;
    pre_reset    = reset;
    pre_addr     = imem_addr;
    pre_ipc      = instr_pc;
    pre_instr    = instruction;
    pre_target   = model_target();
    @(posedge clk);
    #1;
    if (!mem_manual && imem_ack) mem_active = 1'b0;
    if (model_en) model_check();
  endtask

  task automatic clear_br();
    BrTaken = 1'b0; BrReg = 1'b0; UncondBr = 1'b0;
    br_pc = '0; br_instr = '0; reg_target = '0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"}, 64'(imem_req), 64'd0);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(instruction), 64'd0);
    chk({tag, "_ipc"}, instr_pc, 64'd0);
  endtask

  initial begin
    br_tab[0] = '{"b_neg",      1, 0, 1, 64'h100,                 32'h03FFFFFE, 64'h0,                 64'hF8};
    br_tab[1] = '{"cbz_pos",    1, 0, 0, 64'h40,                  32'h00000080, 64'h0,                 64'h50};
    br_tab[2] = '{"brreg_prio", 1, 1, 0, 64'h40,                  32'h00000080, 64'h2000,              64'h2000};
    br_tab[3] = '{"brreg_only", 0, 1, 1, 64'h100,                 32'h03FFFFFE, 64'hDEADBEEF00001000,  64'hDEADBEEF00001000};
    br_tab[4] = '{"b_maxpos",   1, 0, 1, 64'h0,                   32'h01FFFFFF, 64'h0,                 64'h7FFFFFC};
    br_tab[5] = '{"cond_minneg",1, 0, 0, 64'h200000,              32'h00800000, 64'h0,                 64'h100000};
    br_tab[6] = '{"b_wrap",     1, 0, 1, 64'hFFFFFFFFFFFFFFFC,    32'h00000002, 64'h0,                 64'h4};
    br_tab[7] = '{"cond_mask",  1, 0, 0, 64'h1000,                32'hFF00003F, 64'h0,                 64'h1004};

    reset = 1'b1; stall = 1'b0; imem_ack = 1'b0; imem_rdata = '0;
    clear_br();
    mem_manual = 1'b0; mem_maxlat = 0; mem_active = 1'b0; mem_lat = 0;

    // Reset and same-cycle-ack streaming.
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b0;
    #1 chk("idle_req", 64'(imem_req), 64'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("seq_req%0d", i), 64'(imem_req), 64'd1);
      chk($sformatf("seq_addr%0d", i), imem_addr, 64'(4 * i));
      tick();
      chk($sformatf("seq_ipc%0d", i), instr_pc, 64'(4 * i));
      chk($sformatf("seq_valid%0d", i), 64'(instr_valid), 64'd1);
      chk($sformatf("seq_instr%0d", i), 64'(instruction), 64'(mem_word(64'(4 * i))));
    end

    // Stall three cycles, then resume at the next PC.
    stall = 1'b1;
    #1 chk("stall_req0", 64'(imem_req), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("stall_ipc%0d", i), instr_pc, 64'hC);
      chk($sformatf("stall_valid%0d", i), 64'(instr_valid), 64'd1);
      chk($sformatf("stall_req%0d", i), 64'(imem_req), 64'd0);
    end
    stall = 1'b0;
    #1 chk("resume_addr", imem_addr, 64'h10);
    tick();
    chk("resume_ipc", instr_pc, 64'h10);
    chk("resume_instr", 64'(instruction), 64'(mem_word(64'h10)));

    // Redirect target table.
    for (int i = 0; i < 8; i++) begin
      BrTaken = br_tab[i].brtaken; BrReg = br_tab[i].brreg; UncondBr = br_tab[i].uncond;
      br_pc = br_tab[i].bpc; br_instr = br_tab[i].binstr; reg_target = br_tab[i].rtarget;
      tick();
      clear_br();
      #1;
      chk({br_tab[i].name, "_addr"}, imem_addr, br_tab[i].exp_addr);
      chk({br_tab[i].name, "_req"}, 64'(imem_req), 64'd1);
      chk({br_tab[i].name, "_flush"}, 64'(instr_valid), 64'd0);
    end

    // Redirect while the request waits three cycles for its ack.
    mem_manual = 1'b1; imem_ack = 1'b0;
    a_hold = imem_addr;
    BrReg = 1'b1; reg_target = 64'h80;
    tick();
    clear_br();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      chk($sformatf("drop_addr%0d", i), imem_addr, a_hold);
      chk($sformatf("drop_req%0d", i), 64'(imem_req), 64'd1);
      chk($sformatf("drop_valid%0d", i), 64'(instr_valid), 64'd0);
    end
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("drop_discard", 64'(instr_valid), 64'd0);
    chk("drop_target", imem_addr, 64'h80);
    imem_ack = 1'b1; imem_rdata = mem_word(64'h80);
    tick();
    imem_ack = 1'b0;
    chk("drop_ipc", instr_pc, 64'h80);
    chk("drop_instr", 64'(instruction), 64'(mem_word(64'h80)));
    chk("drop_v", 64'(instr_valid), 64'd1);

    // A second redirect during DROP replaces the pending target.
    BrReg = 1'b1; reg_target = 64'h80;
    tick();
    reg_target = 64'h300;
    tick();
    clear_br();
    imem_ack = 1'b1; imem_rdata = 32'h0BAD0BAD;
    tick();
    imem_ack = 1'b0;
    #1;
    chk("overwrite_addr", imem_addr, 64'h300);
    chk("overwrite_valid", 64'(instr_valid), 64'd0);

    // Reset mid-request with a late ack.
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("midrst");
    imem_ack = 1'b1; imem_rdata = 32'hBAD0BAD0;
    tick();
    reset = 1'b0;
    #1 chk("late_req_idle", 64'(imem_req), 64'd0);
    tick();
    imem_ack = 1'b0;
    #1;
    chk("late_req", 64'(imem_req), 64'd1);
    chk("late_addr", imem_addr, 64'h0);
    chk("late_valid", 64'(instr_valid), 64'd0);
    chk("late_instr", 64'(instruction), 64'd0);

    // Randomized run against the instruction-stream model.
    mem_manual = 1'b0; mem_maxlat = 3; mem_active = 1'b0;
    model_en = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      int unsigned r;
      stall = ($urandom_range(0, 9) < 3);
      r = $urandom_range(0, 19);
      BrTaken    = (r == 0);
      BrReg      = (r == 1);
      UncondBr   = 1'($urandom());
      br_pc      = {$urandom(), $urandom()};
      br_instr   = $urandom();
      reg_target = {$urandom(), $urandom()};
      tick();
    end
    clear_br();
    stall = 1'b0;
    model_en = 1'b0;
    chk("liveness", 64'(consumed > 200), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
